// File: rtl/reg_bus_master_pkg.sv
// Shared types for the register-bus initiator.
// Phase state codes and phase-counter sizing.
package reg_bus_master_pkg;

  localparam int CNT_W = 4;

  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  function automatic logic [CNT_W-1:0]
    cnt_load(input int n);
    return CNT_W'(n);
  endfunction

endpackage

// File: rtl/reg_bus_master.sv
// Register-bus initiator: valid/ready commands become setup/strobe/hold
// bus cycles. Ports: cmd_* in, rsp_* out, bus_* out (all flops), bus_data_in.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [1:0]            cmd_be,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data_out,
  output logic                  bus_data_oe,
  input  logic [DATA_WIDTH-1:0] bus_data_in
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES out of range 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES out of range 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES out of range 1..15");
  end

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic                  ready_q, ready_d;
  logic                  rsp_q, rsp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  en_q, en_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [1:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  last;

  assign last = (cnt_q == CNT_ONE);

  // Bus outputs are computed for the next state so every pin is a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    rsp_d   = 1'b0;
    rdata_d = rdata_q;
    en_d    = en_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    be_d    = be_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          be_d    = cmd_be;
          dout_d  = cmd_write ? cmd_wdata : '0;
          oe_d    = cmd_write;
          en_d    = 1'b1;
          cnt_d   = cnt_load(SETUP_CYCLES);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (last) begin
          rd_d    = ~write_q;
          wr_d    = write_q;
          cnt_d   = cnt_load(STROBE_CYCLES);
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_STROBE: begin
        if (last) begin
          if (!write_q) begin
            rdata_d = bus_data_in;
          end
          cnt_d   = cnt_load(HOLD_CYCLES);
          state_d = ST_HOLD;
        end else begin
          rd_d  = ~write_q;
          wr_d  = write_q;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (last) begin
          en_d    = 1'b0;
          oe_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          dout_d  = '0;
          rsp_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign bus_en       = en_q;
  assign bus_rd       = rd_q;
  assign bus_wr       = wr_q;
  assign bus_be       = be_q;
  assign bus_addr     = addr_q;
  assign bus_data_out = dout_q;
  assign bus_data_oe  = oe_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: scoreboard on rsp_valid plus directed
// phase-timing tables, a simple register-file model on the bus.
module tb_reg_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        bus_en, bus_rd, bus_wr, bus_data_oe;
  logic [1:0]  bus_be;
  logic [15:0] bus_addr, bus_data_out, bus_data_in;

  logic        b_cmd_valid, b_cmd_ready, b_cmd_write;
  logic [15:0] b_cmd_addr, b_cmd_wdata;
  logic [1:0]  b_cmd_be;
  logic        b_rsp_valid;
  logic [15:0] b_rsp_rdata;
  logic        b_bus_en, b_bus_rd, b_bus_wr, b_bus_data_oe;
  logic [1:0]  b_bus_be;
  logic [15:0] b_bus_addr, b_bus_data_out;
  logic [15:0] b_bus_data_in;

  reg_bus_master dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_en(bus_en), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
    .bus_data_in(bus_data_in)
  );

  reg_bus_master #(
    .SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_write(b_cmd_write), .cmd_addr(b_cmd_addr),
    .cmd_be(b_cmd_be), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .bus_en(b_bus_en), .bus_rd(b_bus_rd), .bus_wr(b_bus_wr),
    .bus_be(b_bus_be), .bus_addr(b_bus_addr),
    .bus_data_out(b_bus_data_out), .bus_data_oe(b_bus_data_oe),
    .bus_data_in(b_bus_data_in)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Register-file model: latches on the falling edge of wr.
  logic [15:0] regs [16];
  logic        preload = 1'b0;
  always @(negedge bus_wr or posedge preload) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
      regs[3] = 16'hAAAA;
      regs[7] = 16'h5A5A;
    end else if (bus_en === 1'b1) begin
      if (bus_be[0]) regs[bus_addr[3:0]][7:0]  = bus_data_out[7:0];
      if (bus_be[1]) regs[bus_addr[3:0]][15:8] = bus_data_out[15:8];
    end
  end
  assign bus_data_in = bus_rd ? regs[bus_addr[3:0]] : 16'h0000;

  typedef struct {
    logic [15:0] rdata;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected none");
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, mon_e.rdata);
          chk("rsp_cycle", cyc, mon_e.cyc);
          chk("rsp_en_low", bus_en, 0);
        end
      end
      if (cmd_valid && cmd_ready) chk("accept_idle", bus_en, 0);
      chk("rd_wr_excl", bus_rd & bus_wr, 0);
      chk("oe_in_rd", bus_data_oe & bus_rd, 0);
      if (bus_rd | bus_wr) chk("strobe_after_en", prev_en, 1);
    end
    prev_en = bus_en;
  end

  task automatic issue(input logic w, input logic [15:0] a,
                       input logic [1:0] be, input logic [15:0] d,
                       input logic [15:0] exp_rd);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_be    = be;
    cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got no cmd_ready expected ready");
      cmd_valid = 1'b0;
      return;
    end
    sb.push_back('{rdata: exp_rd, cyc: cyc + 5});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = ~cmd_write;
    cmd_addr  = 16'hFFFF;
    cmd_wdata = 16'hDEAD;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [5:1] t1_en  = 5'b01111;
  logic [5:1] t1_wr  = 5'b00110;
  logic [5:1] t1_rsp = 5'b10000;
  logic [8:1] t6_en  = 8'b00111111;
  logic [8:1] t6_wr  = 8'b00001000;
  logic [8:1] t6_rsp = 8'b01000000;

  initial begin
    reset = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_be = 0; cmd_wdata = 0;
    b_cmd_valid = 0; b_cmd_write = 0; b_cmd_addr = 0; b_cmd_be = 0;
    b_cmd_wdata = 0; b_bus_data_in = 16'h0000;
    #1 preload = 1'b1;
    #1 preload = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_en", bus_en, 0);
    chk("rst_rd", bus_rd, 0);
    chk("rst_wr", bus_wr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_dout", bus_data_out, 0);
    chk("rst_oe", bus_data_oe, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // Full write timing with defaults.
    issue(1'b1, 16'h0005, 2'b11, 16'hBEEF, 16'h0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_addr  = 16'h00FF;
        cmd_wdata = 16'h0000;
      end
      chk($sformatf("t1_en_c%0d", k), bus_en, t1_en[k]);
      chk($sformatf("t1_wr_c%0d", k), bus_wr, t1_wr[k]);
      chk($sformatf("t1_oe_c%0d", k), bus_data_oe, t1_en[k]);
      chk($sformatf("t1_rsp_c%0d", k), rsp_valid, t1_rsp[k]);
      chk($sformatf("t1_addr_c%0d", k), bus_addr,
          t1_en[k] ? 32'h5 : 32'h0);
    end
    issue(1'b0, 16'h0005, 2'b11, 16'h0000, 16'hBEEF);
    idle();
    drain();

    // Low-byte write, read-back merge, read, zero byte-enable write.
    issue(1'b1, 16'h0003, 2'b01, 16'h1234, 16'hBEEF);
    idle();
    issue(1'b0, 16'h0003, 2'b11, 16'h0000, 16'hAA34);
    idle();
    issue(1'b0, 16'h0007, 2'b11, 16'h0000, 16'h5A5A);
    idle();
    issue(1'b1, 16'h0005, 2'b00, 16'h0000, 16'h5A5A);
    idle();
    issue(1'b0, 16'h0005, 2'b11, 16'h0000, 16'hBEEF);
    idle();
    drain();

    // Four commands with cmd_valid held high.
    issue(1'b1, 16'h0008, 2'b11, 16'h1111, 16'hBEEF);
    issue(1'b0, 16'h0008, 2'b11, 16'h0000, 16'h1111);
    issue(1'b1, 16'h0008, 2'b10, 16'h2222, 16'h1111);
    issue(1'b0, 16'h0008, 2'b11, 16'h0000, 16'h2211);
    idle();
    drain();

    // Reset during the strobe of a write.
    begin
      int n = 0;
      issue(1'b1, 16'h0009, 2'b11, 16'h7777, 16'h0000);
      idle();
      while (bus_wr !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("t5_wr_seen", bus_wr, 1);
      reset = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("t5_ready", cmd_ready, 0);
      chk("t5_rsp", rsp_valid, 0);
      chk("t5_en", bus_en, 0);
      chk("t5_wr", bus_wr, 0);
      chk("t5_oe", bus_data_oe, 0);
      chk("t5_addr", bus_addr, 0);
      chk("t5_dout", bus_data_out, 0);
      chk("t5_rdata", rsp_rdata, 0);
      chk("t5_nowrite", regs[9], 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_ready_rel", cmd_ready, 1);
      chk("t5_no_rsp", rsp_valid, 0);
    end

    // Non-default phase lengths on the second instance.
    begin
      int n = 0;
      @(negedge clk);
      b_cmd_valid = 1'b1;
      b_cmd_write = 1'b1;
      b_cmd_addr  = 16'h0042;
      b_cmd_be    = 2'b10;
      b_cmd_wdata = 16'hC0DE;
      while (b_cmd_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t6_ready", b_cmd_ready, 1);
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (k == 1) begin
          b_cmd_valid = 1'b0;
          b_cmd_addr  = 16'h0099;
          b_cmd_wdata = 16'hFFFF;
          b_cmd_be    = 2'b01;
        end
        chk($sformatf("t6_en_c%0d", k), b_bus_en, t6_en[k]);
        chk($sformatf("t6_wr_c%0d", k), b_bus_wr, t6_wr[k]);
        chk($sformatf("t6_rsp_c%0d", k), b_rsp_valid, t6_rsp[k]);
        chk($sformatf("t6_addr_c%0d", k), b_bus_addr,
            t6_en[k] ? 32'h42 : 32'h0);
        chk($sformatf("t6_dout_c%0d", k), b_bus_data_out,
            t6_en[k] ? 32'hC0DE : 32'h0);
        chk($sformatf("t6_be_c%0d", k), b_bus_be,
            t6_en[k] ? 32'h2 : 32'h0);
      end
    end

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
